instr_fetch: RTL and testbench

Instruction-fetch stage with a small prefetch queue. It issues word fetches to instruction memory over a req/ack handshake and buffers the returned words with their PCs. It presents one instruction per cycle to decode, where instr[31:7] feeds the immediate extender and the control unit. It also accepts PC redirects (branch/jump targets computed from the extended immediate) and flushes wrong-path instructions.

---
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// instr_fetch: instruction-fetch stage with a small prefetch queue.
//
// It fetches words from instruction memory over a req/ack handshake. Each
// returned word is stored in a DEPTH-entry queue together with its PC. The
// head of the queue goes to decode. A redirect flushes the queue and
// restarts fetching at a new PC.
//
// Handshakes:
//   imem_req/imem_ack: a fetch completes on a rising edge where imem_req=1
//     and imem_ack=1. imem_addr is held stable while imem_req=1 until that
//     edge. imem_ack is ignored while imem_req=0.
//   valid/ready: decode takes the head entry on a rising edge where
//     valid=1 and ready=1.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   imem_req/addr         fetch request and word-aligned address
//   imem_ack/rdata        memory accept and returned instruction word
//   redirect/redirect_pc  one-cycle flush pulse and new fetch PC (bits[1:0] dropped)
//   valid/ready           decode handshake on the queue head
//   instr/pc/pcplus4      head instruction (nop when empty), its PC (0 when empty), PC+4
//   state_dbg             fetch FSM state: 0=IDLE, 1=REQ, 2=KILL
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid,
  input  logic        ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [1:0]  state_dbg
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  // Address of the request still in flight when a redirect hit it. The
  // redirect moves fetch_pc at once, but the bus address must not change
  // until that stale request is acked.
  logic [31:0]   kill_addr, kill_addr_n;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic [PW-1:0] rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
  logic [CW-1:0] count, count_n, count_popped;
  logic          ack_fire, pop, push;

  assign imem_req  = (state != IDLE);
  assign imem_addr = (state == KILL) ? kill_addr : fetch_pc;
  assign valid     = (count != '0);
  assign instr     = valid ? q_instr[rd_ptr] : 32'h0000_0013;
  assign pc        = valid ? q_pc[rd_ptr] : 32'h0000_0000;
  assign pcplus4   = pc + 32'd4;
  assign state_dbg = state;

  always_comb begin
    ack_fire     = imem_req & imem_ack;
    pop          = valid & ready;
    push         = (state == REQ) & ack_fire & ~redirect;
    count_popped = count - CW'(pop);
    state_n      = state;
    fetch_pc_n   = fetch_pc;
    kill_addr_n  = kill_addr;
    rd_ptr_n     = rd_ptr + PW'(pop);
    wr_ptr_n     = wr_ptr + PW'(push);
    count_n      = count_popped + CW'(push);

    if (redirect) begin
      // A pop in this cycle is still seen by decode, but the queue is emptied anyway.
      fetch_pc_n = redirect_pc & 32'hFFFF_FFFC;
      count_n    = '0;
      rd_ptr_n   = '0;
      wr_ptr_n   = '0;
      if (imem_req && !imem_ack) begin
        // A request is still outstanding. Its data is discarded when it is
        // acked. Coming from KILL, the address in flight is already kill_addr.
        state_n = KILL;
        if (state == REQ) kill_addr_n = fetch_pc;
      end else begin
        // The bus is free, either idle or finishing this edge. Any acked word
        // is dropped, and fetching restarts at the target.
        state_n = REQ;
      end
    end else begin
      case (state)
        IDLE: if (count_popped < DEPTH_C) state_n = REQ;
        REQ: begin
          if (ack_fire) begin
            fetch_pc_n = fetch_pc + 32'd4;
            state_n    = (count_n < DEPTH_C) ? REQ : IDLE;
          end
        end
        KILL: if (ack_fire) state_n = REQ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      kill_addr <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      kill_addr <= kill_addr_n;
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      count     <= count_n;
    end
  end

  // Queue storage needs no reset. An entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
// Testbench for instr_fetch.
// The bench drives a memory model that returns a hashed word for each
// address. A reference model predicts the correct-path instruction stream:
// it starts at RESET_PC, steps sequentially, restarts at each redirect
// target, and discards the one request left in flight by a redirect.
// Expected {pc,instr} pairs are queued when a fetch is accepted. A monitor
// compares the queue head against the DUT outputs every cycle.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        valid;
  logic        ready = 1'b0;
  logic [31:0] instr, pc, pcplus4;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .valid(valid), .ready(ready),
    .instr(instr), .pc(pc), .pcplus4(pcplus4),
    .state_dbg(state_dbg)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  always_comb imem_rdata = mem_word(imem_addr);

  // ---------------- scoreboard state ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];          // {pc, instr} expected at decode, in order
  logic [31:0] next_fetch = RESET_PC;
  bit          stale = 1'b0;      // a killed request is still outstanding

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- memory ack driver ----------------
  int ack_wait = 0;
  bit ack_rand = 1'b0;

  initial begin
    int  wcnt;
    bit  fire, busy;
    wcnt = 0;
    forever begin
      @(negedge clk);
      fire = imem_req & imem_ack;
      busy = imem_req;
      @(posedge clk);
      #1;
      if (fire || !busy || reset) wcnt = 0;
      else wcnt++;
      if (ack_rand) imem_ack = ($urandom_range(0, 2) == 0);
      else          imem_ack = (wcnt >= ack_wait);
    end
  end

  // ---------------- expectation producer ----------------
  // Runs just after the monitor in each cycle. It applies the upcoming edge:
  // redirect, accepted fetch, or reset.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      exp_q.delete();
      next_fetch = RESET_PC;
      stale      = 1'b0;
    end else if (redirect) begin
      exp_q.delete();
      next_fetch = redirect_pc & 32'hFFFF_FFFC;
      stale      = imem_req & ~imem_ack;
    end else if (imem_req && imem_ack) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        check("fetch_addr", imem_addr, next_fetch);
        check("push_not_full", 32'(exp_q.size() < DEPTH), 32'd1);
        exp_q.push_back({next_fetch, mem_word(next_fetch)});
        next_fetch = next_fetch + 32'd4;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [63:0] head;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_pc", pc, 32'h0);
      check("rst_pcplus4", pcplus4, 32'h4);
      prev_req = 1'b0;
    end else begin
      check("valid", 32'(valid), 32'(exp_q.size() != 0));
      if (valid && exp_q.size() != 0) begin
        head = exp_q[0];
        check("pc", pc, head[63:32]);
        check("instr", instr, head[31:0]);
        check("pcplus4", pcplus4, head[63:32] + 32'd4);
        if (ready) void'(exp_q.pop_front());
      end else if (!valid) begin
        check("idle_instr", instr, 32'h0000_0013);
        check("idle_pc", pc, 32'h0);
        check("idle_pcplus4", pcplus4, 32'h4);
      end
      if (exp_q.size() == DEPTH) check("full_req_low", 32'(imem_req), 32'd0);
      if (prev_req && !prev_ack) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_stable", imem_addr, prev_addr);
      end
      prev_req = imem_req;
    end
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    ready    = 1'b1;
    ack_wait = 0;
    reset    = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("first_cycle_idle", 32'(imem_req), 32'd0);
    tick();
    check("req_after_idle", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    repeat (20) tick();

    // Two wait states per fetch.
    ack_wait = 2;
    repeat (24) tick();

    // Decode stalls until the queue fills, then drains.
    ack_wait = 0;
    ready    = 1'b0;
    repeat (6) tick();
    check("stall_req_low", 32'(imem_req), 32'd0);
    ready = 1'b1;
    repeat (8) tick();

    // Redirect while a request to 0x40 is still waiting for its ack.
    ack_wait = 3;
    pulse_redirect(32'h0000_0040);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && state_dbg == 2'd1 && imem_addr == 32'h40 && !imem_ack) found = 1'b1;
      else tick();
    end
    check("kill_setup", 32'(found), 32'd1);
    if (found) begin
      pulse_redirect(32'h0000_2002);
      check("kill_state", 32'(state_dbg), 32'd2);
      check("kill_addr_hold", imem_addr, 32'h40);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
        if (valid) found = 1'b1;
        else tick();
      end
      check("kill_target_valid", 32'(found), 32'd1);
      check("kill_first_pc", pc, 32'h2000);
    end
    repeat (6) tick();

    // Redirect in the same cycle as an ack and a pop.
    ack_wait = 0;
    repeat (5) tick();
    check("redir_pop_setup", 32'(valid & imem_ack & imem_req), 32'd1);
    pulse_redirect(32'h0000_3001);
    check("redir_flush", 32'(valid), 32'd0);
    check("redir_addr", imem_addr, 32'h3000);
    repeat (6) tick();

    // Fetch PC wraps modulo 2^32.
    pulse_redirect(32'hFFFF_FFF4);
    repeat (8) tick();

    // Reset while a request waits, followed by an ack that arrives too late.
    ack_wait = 3;
    repeat (2) tick();
    check("rst_mid_setup", 32'(imem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async_req", 32'(imem_req), 32'd0);
    check("rst_async_valid", 32'(valid), 32'd0);
    ack_wait = 0;
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();

    // Random traffic.
    ack_rand = 1'b1;
    for (int i = 0; i < 700; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
      end else if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) pulse_redirect(32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
        else                           pulse_redirect($urandom());
      end else begin
        tick();
      end
    end
    ack_rand = 1'b0;
    ready    = 1'b1;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
